// File: rtl/acc_mq_muldp.sv
// rtl/acc_mq_muldp.sv - accumulator/MQ/DR datapath with single-cycle ALU ops
// and a shift-add unsigned multiplier sequenced by a three-state FSM.
module acc_mq_muldp #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       INS,
  input  logic             LDAcc,
  input  logic             LDMQ,
  input  logic             LDDR,
  input  logic             STAcc,
  input  logic             STMQ,
  input  logic             STDR,
  input  logic [WIDTH-1:0] inBUS,
  output logic [WIDTH-1:0] outBUS,
  output logic             RDY,
  output logic             done,
  output logic             carry
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] acc, mq, dr;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   mul_sum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    RDY       = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        RDY = 1'b1;
        if (start) state_nxt = (INS == OP_MUL) ? S_MUL : S_DONE;
      end
      S_MUL:   if (cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    add_sum = {1'b0, acc} + {1'b0, dr};
    mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, dr} : {(WIDTH+1){1'b0}});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      mq    <= '0;
      dr    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (INS)
              OP_ADD: {carry, acc} <= add_sum;
              OP_SUB: begin
                carry <= (acc >= dr);
                acc   <= acc - dr;
              end
              OP_AND: begin acc <= acc & dr; carry <= 1'b0; end
              OP_OR:  begin acc <= acc | dr; carry <= 1'b0; end
              OP_XOR: begin acc <= acc ^ dr; carry <= 1'b0; end
              OP_MUL: begin
                acc   <= '0;
                carry <= 1'b0;
                cnt   <= '0;
              end
              // {carry,Acc,MQ} shifted right as one vector
              OP_SHR: begin
                acc   <= {carry, acc[WIDTH-1:1]};
                mq    <= {acc[0], mq[WIDTH-1:1]};
                carry <= 1'b0;
              end
              OP_CLR: begin acc <= '0; carry <= 1'b0; end
              default: ;
            endcase
          end else begin
            if (LDAcc) acc <= inBUS;
            if (LDMQ)  mq  <= inBUS;
            if (LDDR)  dr  <= inBUS;
          end
        end
        S_MUL: begin
          acc   <= mul_sum[WIDTH:1];
          mq    <= {mul_sum[0], mq[WIDTH-1:1]};
          carry <= 1'b0;
          cnt   <= cnt + CNTW'(1);
        end
        default: ;
      endcase
    end
  end

  assign outBUS = ({WIDTH{STAcc}} & acc) | ({WIDTH{STMQ}} & mq) | ({WIDTH{STDR}} & dr);

endmodule

// File: tb/tb_acc_mq_muldp.sv
// tb/tb_acc_mq_muldp.sv - randomized self-checking bench for acc_mq_muldp
// against an arithmetic reference model, plus directed corner cases.
`timescale 1ns/100ps
module tb_acc_mq_muldp;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] INS = '0;
  logic       LDAcc = 0, LDMQ = 0, LDDR = 0, STAcc = 0, STMQ = 0, STDR = 0;
  logic [7:0] inBUS = '0;
  logic [7:0] outBUS;
  logic       RDY, done, carry;

  logic        w_start = 1'b0;
  logic [2:0]  w_ins = '0;
  logic        w_ldacc = 0, w_ldmq = 0, w_lddr = 0, w_stacc = 0, w_stmq = 0, w_stdr = 0;
  logic [15:0] w_inbus = '0;
  logic [15:0] w_outbus;
  logic        w_rdy, w_done, w_carry;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_acc = '0, m_mq = '0, m_dr = '0;
  logic       m_c = 1'b0;

  always #10 clock = ~clock;

  acc_mq_muldp #(.WIDTH(8)) u_dut (
    .clock(clock), .reset(reset), .start(start), .INS(INS),
    .LDAcc(LDAcc), .LDMQ(LDMQ), .LDDR(LDDR),
    .STAcc(STAcc), .STMQ(STMQ), .STDR(STDR),
    .inBUS(inBUS), .outBUS(outBUS), .RDY(RDY), .done(done), .carry(carry)
  );

  acc_mq_muldp #(.WIDTH(16)) u_dut16 (
    .clock(clock), .reset(reset), .start(w_start), .INS(w_ins),
    .LDAcc(w_ldacc), .LDMQ(w_ldmq), .LDDR(w_lddr),
    .STAcc(w_stacc), .STMQ(w_stmq), .STDR(w_stdr),
    .inBUS(w_inbus), .outBUS(w_outbus), .RDY(w_rdy), .done(w_done), .carry(w_carry)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic verify(input string tag);
    {STAcc, STMQ, STDR} = 3'b100; #0.5 check({tag, ".acc"}, 32'(outBUS), 32'(m_acc));
    {STAcc, STMQ, STDR} = 3'b010; #0.5 check({tag, ".mq"},  32'(outBUS), 32'(m_mq));
    {STAcc, STMQ, STDR} = 3'b001; #0.5 check({tag, ".dr"},  32'(outBUS), 32'(m_dr));
    {STAcc, STMQ, STDR} = 3'b111; #0.5 check({tag, ".or"},  32'(outBUS), 32'(m_acc | m_mq | m_dr));
    {STAcc, STMQ, STDR} = 3'b000; #0.5 check({tag, ".none"}, 32'(outBUS), 32'h0);
    check({tag, ".carry"}, 32'(carry), 32'(m_c));
  endtask

  task automatic load(input logic [2:0] mask, input logic [7:0] v);
    @(negedge clock);
    {LDAcc, LDMQ, LDDR} = mask;
    inBUS = v;
    @(posedge clock); #1;
    {LDAcc, LDMQ, LDDR} = 3'b000;
    if (mask[2]) m_acc = v;
    if (mask[1]) m_mq  = v;
    if (mask[0]) m_dr  = v;
  endtask

  task automatic model_op(input logic [2:0] op);
    logic [15:0] prod;
    logic [16:0] wide;
    case (op)
      3'd0: {m_c, m_acc} = {1'b0, m_acc} + {1'b0, m_dr};
      3'd1: begin m_c = (m_acc >= m_dr); m_acc = m_acc - m_dr; end
      3'd2: begin m_acc = m_acc & m_dr; m_c = 0; end
      3'd3: begin m_acc = m_acc | m_dr; m_c = 0; end
      3'd4: begin m_acc = m_acc ^ m_dr; m_c = 0; end
      3'd5: begin
        prod  = 16'(m_mq) * 16'(m_dr);
        m_acc = prod[15:8];
        m_mq  = prod[7:0];
        m_c   = 0;
      end
      3'd6: begin
        wide = {m_c, m_acc, m_mq} >> 1;
        {m_acc, m_mq} = wide[15:0];
        m_c = 0;
      end
      default: begin m_acc = '0; m_c = 0; end
    endcase
  endtask

  // ldmask is asserted alongside start and must be discarded; inject disturbs a MUL.
  task automatic exec(input logic [2:0] op, input logic [2:0] ldmask, input bit inject);
    int lat;
    @(negedge clock);
    INS = op; start = 1'b1;
    {LDAcc, LDMQ, LDDR} = ldmask;
    inBUS = 8'($urandom);
    @(posedge clock); #1;
    start = 1'b0;
    {LDAcc, LDMQ, LDDR} = 3'b000;
    lat = 1;
    while (!done && lat < 40) begin
      check("busy_rdy", 32'(RDY), 32'h0);
      if (inject && lat == 3) begin
        LDAcc = 1'b1; inBUS = 8'h55; start = 1'b1; INS = 3'b111;
      end
      @(posedge clock); #1;
      LDAcc = 1'b0; start = 1'b0;
      lat++;
    end
    check("latency", 32'(lat), (op == 3'd5) ? 32'd9 : 32'd1);
    check("done_rdy", 32'(RDY), 32'h0);
    model_op(op);
    verify("result");
    @(posedge clock); #1;
    check("idle_done", 32'(done), 32'h0);
    check("idle_rdy", 32'(RDY), 32'h1);
  endtask

  initial begin
    int lat;
    #3;
    check("rst_rdy", 32'(RDY), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    verify("rst");
    @(negedge clock); reset = 1'b0;

    // ADD with carry out
    load(3'b100, 8'hF0); load(3'b001, 8'h20);
    exec(3'd0, 3'b000, 0);
    check("add_const_carry", 32'(carry), 32'h1);
    // SUB with borrow
    load(3'b100, 8'h10);
    exec(3'd1, 3'b000, 0);
    STAcc = 1'b1; #0.5 check("sub_const_acc", 32'(outBUS), 32'hF0); STAcc = 1'b0;
    // MUL 0xFF*0xFF
    load(3'b011, 8'hFF);
    exec(3'd5, 3'b000, 0);
    STAcc = 1'b1; #0.5 check("mul_const_acc", 32'(outBUS), 32'hFE); STAcc = 1'b0;
    STMQ = 1'b1;  #0.5 check("mul_const_mq", 32'(outBUS), 32'h01);  STMQ = 1'b0;
    // same MUL with LD and start disturbances mid-run
    load(3'b011, 8'hFF);
    exec(3'd5, 3'b000, 1);
    // LD writes on the accepting edge are dropped
    exec(3'd7, 3'b111, 0);

    // reset during the 4th MUL cycle
    load(3'b111, 8'hA7);
    @(negedge clock); INS = 3'd5; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    m_acc = '0; m_mq = '0; m_dr = '0; m_c = 0;
    check("midrst_rdy", 32'(RDY), 32'h1);
    check("midrst_done", 32'(done), 32'h0);
    verify("midrst");
    @(negedge clock); reset = 1'b0;
    load(3'b011, 8'h03);
    exec(3'd5, 3'b000, 0);

    for (int i = 0; i < 150; i++) begin
      load(3'($urandom_range(0, 7)), 8'($urandom));
      exec(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
    end

    // 16-bit instance: 0x1234 * 0x0010
    @(negedge clock); w_ldmq = 1'b1; w_inbus = 16'h1234;
    @(negedge clock); w_ldmq = 1'b0; w_lddr = 1'b1; w_inbus = 16'h0010;
    @(negedge clock); w_lddr = 1'b0; w_ins = 3'd5; w_start = 1'b1;
    @(posedge clock); #1; w_start = 1'b0;
    lat = 1;
    while (!w_done && lat < 60) begin @(posedge clock); #1; lat++; end
    check("w16_latency", 32'(lat), 32'd17);
    w_stacc = 1'b1; #0.5 check("w16_acc", 32'(w_outbus), 32'h0001); w_stacc = 1'b0;
    w_stmq = 1'b1;  #0.5 check("w16_mq", 32'(w_outbus), 32'h2340);  w_stmq = 1'b0;
    check("w16_carry", 32'(w_carry), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
